// File: rtl/pipe_fetch_stage.sv
// Purpose : fetch stage of the 5-stage ARM pipeline: owns the fetch PC, drives the imem
//           req/ack handshake, absorbs redirects, stalls and flushes, and loads IF/ID.
// Latency : ack in cycle N -> instruction visible on IF/ID in cycle N+1. Zero-wait memory gives 1 instr/cycle.
// Backpr. : stall_d holds IF/ID. A word acked under stall parks in a one-entry buffer (HOLD, no request).
// Ports   : clk/rst_n; hazard stall_d/flush_d; execute branch_taken_e/branch_target_e;
//           imem_req/imem_addr/imem_ack/imem_rdata; IF/ID instr_d/valid_d/pc_d/pc_plus8_d.
module pipe_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken_e,
    input  logic [31:0] branch_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc8_q, ifid_pc8_d;

    // Word-aligned redirect target; the low two bits of the request are ignored.
    logic [31:0] target;
    logic        unused_tgt_bits;
    assign target          = {branch_target_e[31:2], 2'b00};
    assign unused_tgt_bits = ^branch_target_e[1:0];

    // IF/ID load decisions made by the FSM, applied in one place below.
    logic        load_bubble;
    logic        load_word;
    logic [31:0] word_instr;
    logic [31:0] word_pc;

    // Request is gated by rst_n so it drops the moment reset is asserted.
    assign imem_req  = rst_n && (state_q != ST_HOLD);
    assign imem_addr = req_addr_q;

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        load_bubble  = 1'b0;
        load_word    = 1'b0;
        word_instr   = imem_rdata;
        word_pc      = req_addr_q;

        case (state_q)
            ST_FETCH: begin
                if (branch_taken_e) begin
                    load_bubble = 1'b1;
                    if (imem_ack) begin
                        req_addr_d = target;
                    end else begin
                        // Request outstanding: remember target, discard its response.
                        pc_f_d  = target;
                        state_d = ST_DROP;
                    end
                end else if (imem_ack) begin
                    req_addr_d = req_addr_q + 32'd4;
                    if (stall_d) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = req_addr_q;
                        state_d      = ST_HOLD;
                        load_bubble  = flush_d;
                    end else if (flush_d) begin
                        load_bubble = 1'b1;
                    end else begin
                        load_word = 1'b1;
                    end
                end else begin
                    load_bubble = !stall_d || flush_d;
                end
            end

            ST_HOLD: begin
                if (branch_taken_e) begin
                    load_bubble = 1'b1;
                    req_addr_d  = target;
                    state_d     = ST_FETCH;
                end else if (flush_d) begin
                    // Keep the buffered word; it is delivered once decode can take it.
                    load_bubble = 1'b1;
                end else if (!stall_d) begin
                    load_word  = 1'b1;
                    word_instr = hold_instr_q;
                    word_pc    = hold_pc_q;
                    state_d    = ST_FETCH;
                end
            end

            ST_DROP: begin
                load_bubble = !stall_d || flush_d || branch_taken_e;
                if (branch_taken_e) begin
                    pc_f_d = target;
                    if (imem_ack) begin
                        req_addr_d = target;
                        state_d    = ST_FETCH;
                    end
                end else if (imem_ack) begin
                    req_addr_d = pc_f_q;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc8_d   = ifid_pc8_q;
        if (load_bubble) begin
            ifid_instr_d = 32'd0;
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'd0;
            ifid_pc8_d   = 32'd0;
        end else if (load_word) begin
            ifid_instr_d = word_instr;
            ifid_valid_d = 1'b1;
            ifid_pc_d    = word_pc;
            ifid_pc8_d   = word_pc + 32'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_f_q       <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            ifid_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_pc8_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc8_q   <= ifid_pc8_d;
        end
    end

    assign instr_d    = ifid_instr_q;
    assign valid_d    = ifid_valid_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus8_d = ifid_pc8_q;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Purpose : directed self-checking bench for pipe_fetch_stage (RESET_PC = 0x100).
// Latency : outputs sampled on the falling edge, inputs changed right after sampling.
// Backpr. : memory is either zero-wait (ack = req) or driven per cycle by the scenario.
module tb_pipe_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hE5A0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_d, flush_d, branch_taken_e;
    logic [31:0] branch_target_e;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_d, pc_d, pc_plus8_d;
    logic        valid_d;

    logic        zero_wait;
    logic        ack_man;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Memory model: instruction word is the address scrambled with a fixed key.
    assign imem_ack   = zero_wait ? imem_req : ack_man;
    assign imem_rdata = imem_addr ^ KEY;

    pipe_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .branch_taken_e (branch_taken_e),
        .branch_target_e(branch_target_e),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_d        (instr_d),
        .valid_d        (valid_d),
        .pc_d           (pc_d),
        .pc_plus8_d     (pc_plus8_d)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_d = 0; flush_d = 0; branch_taken_e = 0;
        branch_target_e = 0; zero_wait = 1'b1; ack_man = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid_d); end
        total++; if (pc_d !== 32'd0 || pc_plus8_d !== 32'd0 || instr_d !== 32'd0) begin
            bad++; $display("FAIL rst_ifid got pc=%h pc8=%h instr=%h want 0", pc_d, pc_plus8_d, instr_d); end
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            bad++; $display("FAIL rst_first_req got req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC); end
    endtask

    // Zero-wait streaming; ends with 0x108 in IF/ID and 0x10C being requested.
    task automatic test_stream();
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (imem_addr !== RPC + 4*k) begin
                bad++; $display("FAIL stream_addr%0d got=%h want=%h", k, imem_addr, RPC + 4*k); end
            total++; if (valid_d !== 1'b1 || pc_d !== RPC + 4*(k-1) || pc_plus8_d !== RPC + 4*(k-1) + 8
                         || instr_d !== ((RPC + 4*(k-1)) ^ KEY)) begin
                bad++; $display("FAIL stream_ifid%0d got v=%b pc=%h pc8=%h instr=%h want pc=%h", k,
                                valid_d, pc_d, pc_plus8_d, instr_d, RPC + 4*(k-1)); end
        end
    endtask

    task automatic test_stall_buffer();
        stall_d = 1'b1;                     // acked word 0x10C goes into the buffer
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (imem_req !== 1'b0 || valid_d !== 1'b1 || pc_d !== 32'h108) begin
                bad++; $display("FAIL stall_hold%0d got req=%b v=%b pc=%h want 0/1/108", c, imem_req, valid_d, pc_d); end
        end
        stall_d = 1'b0;
        tick();
        total++; if (valid_d !== 1'b1 || pc_d !== 32'h10C || instr_d !== (32'h10C ^ KEY)) begin
            bad++; $display("FAIL stall_release got v=%b pc=%h instr=%h want pc=10C", valid_d, pc_d, instr_d); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin
            bad++; $display("FAIL stall_next_req got req=%b addr=%h want 1/110", imem_req, imem_addr); end
        tick();
        total++; if (pc_d !== 32'h110 || imem_addr !== 32'h114) begin
            bad++; $display("FAIL stall_no_dup got pc=%h addr=%h want 110/114", pc_d, imem_addr); end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        zero_wait = 1'b0;
        for (int n = 0; n < 2; n++) begin
            a = 32'h114 + 4*n;
            ack_man = 1'b0;
            for (int w = 0; w < 3; w++) begin
                tick();
                total++; if (valid_d !== 1'b0 || imem_addr !== a || imem_req !== 1'b1) begin
                    bad++; $display("FAIL wait%0d_%0d got v=%b addr=%h want 0/%h", n, w, valid_d, imem_addr, a); end
            end
            ack_man = 1'b1;
            tick();
            total++; if (valid_d !== 1'b1 || pc_d !== a || imem_addr !== a + 4) begin
                bad++; $display("FAIL wait_deliver%0d got v=%b pc=%h addr=%h want pc=%h", n, valid_d, pc_d, imem_addr, a); end
        end
        ack_man = 1'b0;
    endtask

    task automatic test_redirect_wait();
        ack_man = 1'b1; branch_taken_e = 1'b1; branch_target_e = 32'h200;
        tick();
        total++; if (imem_addr !== 32'h200 || valid_d !== 1'b0) begin
            bad++; $display("FAIL redir_ack got addr=%h v=%b want 200/0", imem_addr, valid_d); end
        ack_man = 1'b0; branch_target_e = 32'h403;   // 0x200 now outstanding
        tick();
        branch_taken_e = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || valid_d !== 1'b0) begin
            bad++; $display("FAIL redir_drop got req=%b addr=%h v=%b want 1/200/0", imem_req, imem_addr, valid_d); end
        tick();
        total++; if (imem_addr !== 32'h200) begin
            bad++; $display("FAIL redir_drop_hold got addr=%h want 200", imem_addr); end
        ack_man = 1'b1;                              // stale 0x200 response arrives
        tick();
        total++; if (imem_addr !== 32'h400 || valid_d !== 1'b0) begin
            bad++; $display("FAIL redir_target got addr=%h v=%b want 400/0", imem_addr, valid_d); end
        tick();
        total++; if (valid_d !== 1'b1 || pc_d !== 32'h400 || instr_d !== (32'h400 ^ KEY)) begin
            bad++; $display("FAIL redir_first got v=%b pc=%h instr=%h want 400", valid_d, pc_d, instr_d); end
        ack_man = 1'b0;
    endtask

    task automatic test_flush_stall();
        flush_d = 1'b1; stall_d = 1'b1;
        tick();
        total++; if (valid_d !== 1'b0 || imem_addr !== 32'h404) begin
            bad++; $display("FAIL flush_over_stall got v=%b addr=%h want 0/404", valid_d, imem_addr); end
        flush_d = 1'b0; ack_man = 1'b1;              // 0x404 acked under stall -> HOLD
        tick();
        total++; if (imem_req !== 1'b0) begin
            bad++; $display("FAIL hold_enter got req=%b want 0", imem_req); end
        ack_man = 1'b0; branch_taken_e = 1'b1; branch_target_e = 32'h500;
        tick();
        branch_taken_e = 1'b0; stall_d = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h500 || valid_d !== 1'b0) begin
            bad++; $display("FAIL hold_redir got req=%b addr=%h v=%b want 1/500/0", imem_req, imem_addr, valid_d); end
        ack_man = 1'b1;
        tick();
        total++; if (valid_d !== 1'b1 || pc_d !== 32'h500) begin
            bad++; $display("FAIL hold_discard got v=%b pc=%h want 1/500", valid_d, pc_d); end
    endtask

    task automatic test_wrap_async_reset();
        branch_taken_e = 1'b1; branch_target_e = 32'hFFFF_FFFC;
        tick();
        branch_taken_e = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_target got addr=%h want FFFFFFFC", imem_addr); end
        tick();
        total++; if (pc_d !== 32'hFFFF_FFFC || pc_plus8_d !== 32'h4 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap got pc=%h pc8=%h addr=%h want FFFFFFFC/4/0", pc_d, pc_plus8_d, imem_addr); end
        tick();
        total++; if (pc_d !== 32'h0 || pc_plus8_d !== 32'h8 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL wrap_next got pc=%h pc8=%h addr=%h want 0/8/4", pc_d, pc_plus8_d, imem_addr); end
        #2 rst_n = 1'b0;                             // mid-cycle, no clock edge
        #1;
        total++; if (valid_d !== 1'b0 || imem_req !== 1'b0 || pc_d !== 32'h0) begin
            bad++; $display("FAIL async_rst got v=%b req=%b pc=%h want 0/0/0", valid_d, imem_req, pc_d); end
        ack_man = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            bad++; $display("FAIL async_rst_release got req=%b addr=%h want 1/%h", imem_req, imem_addr, RPC); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_buffer();
        test_wait_states();
        test_redirect_wait();
        test_flush_stall();
        test_wrap_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
